// File: rtl/eth_pkg.sv
// Shared constants for the Ethernet II header parser: header geometry,
// type/length classification thresholds and the parser state encoding.
package eth_pkg;

  localparam int          HEADER_BYTES  = 14;
  localparam logic [15:0] MAX_LENGTH    = 16'd1500;
  localparam logic [15:0] MIN_ETHERTYPE = 16'h0600;

  localparam int MAC_W = 48;
  localparam int TL_W  = 16;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t DEST = 3'd1;
  localparam state_t SRC  = 3'd2;
  localparam state_t TYPE = 3'd3;
  localparam state_t DONE = 3'd4;

endpackage

// File: rtl/eth_tl_classify.sv
// Combinational type/length classifier: values up to MAX_LENGTH are 802.3
// lengths, values from MIN_ETHERTYPE up are EtherTypes, the gap is reserved.
module eth_tl_classify
  import eth_pkg::*;
(
  input  logic [TL_W-1:0] tl,
  output logic            is_length,
  output logic            reserved
);

  assign is_length = (tl <= MAX_LENGTH);
  assign reserved  = (tl > MAX_LENGTH) && (tl < MIN_ETHERTYPE);

endmodule

// File: rtl/eth_header_parser.sv
// Ethernet II header parser: shifts the 14 header bytes into the destination
// MAC, source MAC and type/length registers while enable_header is high,
// then qualifies the type/length field or flags truncated/reserved headers.
module eth_header_parser
  import eth_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_header,
  input  logic [7:0]       data,
  output logic [MAC_W-1:0] dest_mac,
  output logic [MAC_W-1:0] src_mac,
  output logic [TL_W-1:0]  type_length,
  output logic             is_length,
  output logic             type_length_valid,
  output logic             header_error
);

  // Byte indices that end each field.
  localparam logic [3:0] LAST_DEST = 4'd5;
  localparam logic [3:0] LAST_SRC  = 4'd11;
  localparam logic [3:0] LAST_BYTE = 4'(HEADER_BYTES - 1);

  state_t          state;
  logic [3:0]      byte_cnt;
  logic [TL_W-1:0] tl_next;
  logic            tl_is_length;
  logic            tl_reserved;

  // Type/length as it will look once the current byte is shifted in; this
  // lets the final byte be classified on the same edge that captures it.
  assign tl_next = {type_length[TL_W-9:0], data};

  eth_tl_classify u_classify (
    .tl        (tl_next),
    .is_length (tl_is_length),
    .reserved  (tl_reserved)
  );

  // Header FSM with capture registers and registered status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      byte_cnt          <= 4'd0;
      dest_mac          <= '0;
      src_mac           <= '0;
      type_length       <= '0;
      is_length         <= 1'b0;
      type_length_valid <= 1'b0;
      header_error      <= 1'b0;
    end else begin
      header_error <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_header) begin
            // Start of a new header: drop the previous frame's fields.
            dest_mac          <= {{(MAC_W-8){1'b0}}, data};
            src_mac           <= '0;
            type_length       <= '0;
            is_length         <= 1'b0;
            type_length_valid <= 1'b0;
            byte_cnt          <= 4'd1;
            state             <= DEST;
          end
        end
        DEST, SRC, TYPE: begin
          if (!enable_header) begin
            // Truncated header: partial fields stay but are never qualified.
            header_error <= 1'b1;
            byte_cnt     <= 4'd0;
            state        <= IDLE;
          end else begin
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt <= LAST_DEST)
              dest_mac <= {dest_mac[MAC_W-9:0], data};
            else if (byte_cnt <= LAST_SRC)
              src_mac <= {src_mac[MAC_W-9:0], data};
            else
              type_length <= tl_next;

            if (byte_cnt == LAST_DEST) begin
              state <= SRC;
            end else if (byte_cnt == LAST_SRC) begin
              state <= TYPE;
            end else if (byte_cnt == LAST_BYTE) begin
              state             <= DONE;
              type_length_valid <= ~tl_reserved;
              is_length         <= tl_is_length;
              header_error      <= tl_reserved;
            end
          end
        end
        DONE: begin
          // Trailing bytes are ignored until the FSM drops enable_header.
          if (!enable_header) begin
            type_length_valid <= 1'b0;
            byte_cnt          <= 4'd0;
            state             <= IDLE;
          end
        end
        default: begin
          byte_cnt <= 4'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
